// File: rtl/conv_stream_engine.sv
// rtl/conv_stream_engine.sv - streaming KxK multi-channel convolution engine with line buffer
module conv_stream_engine #(
    parameter int FP_LENGTH = 16,
    parameter int FRAC_BITS = 8,
    parameter int K         = 5,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int NUM_CH    = 4,
    parameter int ACC_W     = 2*FP_LENGTH+8,
    parameter int WT_AW     = $clog2(NUM_CH*K*K+NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic                        i_relu_en,
    input  logic                        i_wt_we,
    input  logic [WT_AW-1:0]            i_wt_addr,
    input  logic [FP_LENGTH-1:0]        i_wt_data,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [FP_LENGTH-1:0]        i_in_data,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [NUM_CH*FP_LENGTH-1:0] o_out_data,
    output logic                        o_out_last,
    output logic                        o_busy,
    output logic                        o_frame_done
);

    localparam int NTAP = K*K;
    localparam int RW   = (K > 1)     ? $clog2(K)     : 1;
    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int HW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int TW   = (NTAP > 1)  ? $clog2(NTAP)  : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_MAC    = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    localparam logic [RW-1:0] ROW_KM1  = RW'(K-1);
    localparam logic [CW-1:0] COL_KM1  = CW'(K-1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);
    localparam logic [HW-1:0] H_KM1    = HW'(K-1);
    localparam logic [HW-1:0] H_LAST   = HW'(IMG_H-1);
    localparam logic [TW-1:0] TAP_LAST = TW'(NTAP-1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-FP_LENGTH+1){1'b0}}, {(FP_LENGTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-FP_LENGTH+1){1'b1}}, {(FP_LENGTH-1){1'b0}}};

    logic [1:0]                  r_state;
    logic [HW-1:0]               r_row;
    logic [CW-1:0]               r_col;
    logic [RW-1:0]               r_wrow;
    logic [TW-1:0]               r_tap;
    logic [RW-1:0]               r_kx;
    logic [RW-1:0]               r_mrow;
    logic [CW-1:0]               r_bcol;
    logic                        r_relu;
    logic                        r_trig_last;
    logic                        r_frame_done;
    logic signed [ACC_W-1:0]     r_acc  [NUM_CH];
    logic [FP_LENGTH-1:0]        r_line [K][IMG_W];
    logic [FP_LENGTH-1:0]        r_wt   [NUM_CH][NTAP];
    logic [FP_LENGTH-1:0]        r_bias [NUM_CH];

    logic                        w_in_hs;
    logic                        w_trigger;
    logic                        w_col_wrap;
    logic [RW-1:0]               w_wrow_next;
    logic [CW-1:0]               w_mcol;
    logic signed [FP_LENGTH-1:0] w_pix;
    logic signed [2*FP_LENGTH-1:0] w_prod [NUM_CH];
    logic signed [ACC_W-1:0]     w_sum  [NUM_CH];
    logic signed [ACC_W-1:0]     w_shr  [NUM_CH];
    logic [FP_LENGTH-1:0]        w_res  [NUM_CH];

    assign w_in_hs     = (r_state == S_ACCEPT) && i_in_valid;
    assign w_trigger   = (r_row >= H_KM1) && (r_col >= COL_KM1);
    assign w_col_wrap  = (r_col == COL_LAST);
    assign w_wrow_next = (r_wrow == ROW_KM1) ? '0 : r_wrow + 1'b1;
    assign w_mcol      = r_bcol + CW'(r_kx);
    assign w_pix       = r_line[r_mrow][w_mcol];

    assign o_in_ready   = (r_state == S_ACCEPT);
    assign o_out_valid  = (r_state == S_OUT);
    assign o_out_last   = (r_state == S_OUT) && r_trig_last;
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = r_frame_done;

    // Per-channel tap product, then bias, floor shift, saturation and optional ReLU
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_prod[ch] = w_pix * $signed(r_wt[ch][r_tap]);
            w_sum[ch]  = r_acc[ch] + {{(ACC_W-FP_LENGTH-FRAC_BITS){r_bias[ch][FP_LENGTH-1]}},
                                      r_bias[ch], {FRAC_BITS{1'b0}}};
            w_shr[ch]  = w_sum[ch] >>> FRAC_BITS;
            if (w_shr[ch] > SAT_MAX) begin
                w_res[ch] = SAT_MAX[FP_LENGTH-1:0];
            end else if (w_shr[ch] < SAT_MIN) begin
                w_res[ch] = SAT_MIN[FP_LENGTH-1:0];
            end else begin
                w_res[ch] = w_shr[ch][FP_LENGTH-1:0];
            end
            if (r_relu && w_res[ch][FP_LENGTH-1]) begin
                w_res[ch] = '0;
            end
        end
    end

    // Output vector is only driven while presenting a result; acc is frozen in OUT so it stays stable
    always_comb begin
        o_out_data = '0;
        if (r_state == S_OUT) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                o_out_data[ch*FP_LENGTH +: FP_LENGTH] = w_res[ch];
            end
        end
    end

    // Weight and bias storage, writable only while idle, deliberately not reset
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && i_wt_we) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int t = 0; t < NTAP; t++) begin
                    if (i_wt_addr == WT_AW'(ch*NTAP+t)) begin
                        r_wt[ch][t] <= i_wt_data;
                    end
                end
                if (i_wt_addr == WT_AW'(NUM_CH*NTAP+ch)) begin
                    r_bias[ch] <= i_wt_data;
                end
            end
        end
    end

    // K-row circular line buffer, row slot = image row mod K
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_line[r_wrow][r_col] <= i_in_data;
        end
    end

    // Control FSM, raster counters, tap sequencing and accumulators
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_wrow       <= '0;
            r_tap        <= '0;
            r_kx         <= '0;
            r_mrow       <= '0;
            r_bcol       <= '0;
            r_relu       <= 1'b0;
            r_trig_last  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_acc[ch] <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_row   <= '0;
                        r_col   <= '0;
                        r_wrow  <= '0;
                        r_relu  <= i_relu_en;
                        r_state <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (i_in_valid) begin
                        if (w_col_wrap) begin
                            r_col  <= '0;
                            r_row  <= r_row + 1'b1;
                            r_wrow <= w_wrow_next;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        if (w_trigger) begin
                            // Window top row is (r+1) mod K; leftmost column is c-K+1
                            r_tap       <= '0;
                            r_kx        <= '0;
                            r_mrow      <= w_wrow_next;
                            r_bcol      <= r_col - COL_KM1;
                            r_trig_last <= (r_row == H_LAST) && w_col_wrap;
                            for (int ch = 0; ch < NUM_CH; ch++) begin
                                r_acc[ch] <= '0;
                            end
                            r_state <= S_MAC;
                        end
                    end
                end
                S_MAC: begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        r_acc[ch] <= r_acc[ch] + {{(ACC_W-2*FP_LENGTH){w_prod[ch][2*FP_LENGTH-1]}}, w_prod[ch]};
                    end
                    if (r_tap == TAP_LAST) begin
                        r_state <= S_OUT;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                        if (r_kx == ROW_KM1) begin
                            r_kx   <= '0;
                            r_mrow <= (r_mrow == ROW_KM1) ? '0 : r_mrow + 1'b1;
                        end else begin
                            r_kx <= r_kx + 1'b1;
                        end
                    end
                end
                default: begin
                    if (i_out_ready) begin
                        if (r_trig_last) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_state <= S_ACCEPT;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream_engine.sv
// tb/tb_conv_stream_engine.sv - randomized self-checking bench for conv_stream_engine
module tb_conv_stream_engine;

    localparam int KK = 3;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int NC = 2;
    localparam int NOUT = (H-KK+1)*(W-KK+1);

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_relu_en, i_wt_we;
    logic [4:0]  i_wt_addr;
    logic [15:0] i_wt_data;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [15:0] i_in_data;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_out_data;
    logic        o_out_last, o_busy, o_frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    shortint pix [W*H];
    shortint wt  [NC][KK*KK];
    shortint bias[NC];
    logic [31:0] exp_q[$];

    conv_stream_engine #(
        .FP_LENGTH(16), .FRAC_BITS(8), .K(KK), .IMG_W(W), .IMG_H(H), .NUM_CH(NC)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_relu_en(i_relu_en),
        .i_wt_we(i_wt_we), .i_wt_addr(i_wt_addr), .i_wt_data(i_wt_data),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_out_last(o_out_last), .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [15:0] ref_val(input int ch, input int r, input int c, input bit relu);
        longint s = 0;
        for (int ky = 0; ky < KK; ky++)
            for (int kx = 0; kx < KK; kx++)
                s += longint'(pix[(r-KK+1+ky)*W + (c-KK+1+kx)]) * longint'(wt[ch][ky*KK+kx]);
        s += longint'(bias[ch]) * 256;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic build_exp(input bit relu);
        exp_q.delete();
        for (int r = KK-1; r < H; r++)
            for (int c = KK-1; c < W; c++)
                exp_q.push_back({ref_val(1, r, c, relu), ref_val(0, r, c, relu)});
    endtask

    task automatic clear_params();
        for (int ch = 0; ch < NC; ch++) begin
            bias[ch] = 0;
            for (int t = 0; t < KK*KK; t++) wt[ch][t] = 0;
        end
    endtask

    task automatic load_params();
        for (int ch = 0; ch < NC; ch++)
            for (int t = 0; t < KK*KK; t++) begin
                @(negedge clk);
                i_wt_we = 1'b1; i_wt_addr = 5'(ch*KK*KK+t); i_wt_data = wt[ch][t];
            end
        for (int ch = 0; ch < NC; ch++) begin
            @(negedge clk);
            i_wt_we = 1'b1; i_wt_addr = 5'(NC*KK*KK+ch); i_wt_data = bias[ch];
        end
        @(negedge clk);
        i_wt_addr = 5'd31; i_wt_data = 16'h7FFF;
        @(negedge clk);
        i_wt_we = 1'b0;
    endtask

    task automatic set_identity_frame();
        clear_params();
        wt[0][4] = 16'sh0100;
        for (int i = 0; i < W*H; i++) pix[i] = shortint'(i << 8);
    endtask

    task automatic run_frame(input bit relu, input int ready_pct, input int bp_at,
                             input bit protect, input bit do_abort, input bit lat_chk);
        int pix_idx = 0, out_idx = 0, cyc = 0, abort_cnt = 0, t13 = 0, first_ov = -1;
        bit done = 0, bp_done = 0, in_hs, out_hs;
        logic [31:0] hold_d;
        logic hold_l;
        build_exp(relu);
        @(negedge clk);
        i_start = 1'b1; i_relu_en = relu;
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);
        while (!done && cyc < 4000) begin
            i_wt_we = 1'b0; i_start = 1'b0;
            if (bp_at >= 0 && !bp_done && o_out_valid && out_idx == bp_at) begin
                hold_d = o_out_data; hold_l = o_out_last;
                chk("bp_data_expected", hold_d, exp_q[out_idx]);
                for (int s = 0; s < 20; s++) begin
                    i_out_ready = 1'b0;
                    i_in_valid = (pix_idx < W*H);
                    i_in_data = (pix_idx < W*H) ? pix[pix_idx] : 16'h0;
                    @(posedge clk); @(negedge clk);
                    chk("bp_valid_held", o_out_valid, 1);
                    chk("bp_data_stable", o_out_data, hold_d);
                    chk("bp_last_stable", o_out_last, hold_l);
                    chk("bp_in_ready_low", o_in_ready, 0);
                end
                bp_done = 1;
            end
            if (do_abort && pix_idx == 19) begin
                abort_cnt++;
                if (abort_cnt == 4) begin
                    chk("abort_pre_busy", o_busy, 1);
                    chk("abort_pre_in_ready", o_in_ready, 0);
                    i_in_valid = 1'b0;
                    rst = 1'b0;
                    #1;
                    chk("abort_out_valid", o_out_valid, 0);
                    chk("abort_out_data", o_out_data, 0);
                    chk("abort_out_last", o_out_last, 0);
                    chk("abort_busy", o_busy, 0);
                    chk("abort_in_ready", o_in_ready, 0);
                    chk("abort_frame_done", o_frame_done, 0);
                    @(posedge clk); @(negedge clk);
                    rst = 1'b1;
                    return;
                end
            end
            i_in_valid = (pix_idx < W*H) && ($urandom_range(0, 3) != 0);
            i_in_data = (pix_idx < W*H) ? pix[pix_idx] : 16'h0;
            i_out_ready = ($urandom_range(0, 99) < ready_pct);
            if (protect && cyc == 30) begin
                chk("protect_busy", o_busy, 1);
                i_wt_we = 1'b1; i_wt_addr = 5'd4; i_wt_data = 16'h7FFF; i_start = 1'b1;
            end
            in_hs = i_in_valid && o_in_ready;
            out_hs = o_out_valid && i_out_ready;
            if (lat_chk) begin
                if (in_hs && pix_idx == 12) t13 = cyc;
                if (o_out_valid && first_ov < 0) begin
                    first_ov = cyc;
                    chk("first_out_latency", 64'(cyc - t13), 10);
                end
            end
            if (out_hs) begin
                if (out_idx < exp_q.size()) begin
                    chk($sformatf("out_data[%0d]", out_idx), o_out_data, exp_q[out_idx]);
                    chk($sformatf("out_last[%0d]", out_idx), o_out_last, (out_idx == NOUT-1));
                end else begin
                    chk("extra_output", out_idx, exp_q.size());
                end
                out_idx++;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
            if (in_hs) pix_idx++;
            if (out_hs) begin
                chk("valid_drops_after_accept", o_out_valid, 0);
                if (out_idx == NOUT) begin
                    chk("frame_done_pulse", o_frame_done, 1);
                    chk("idle_after_frame", o_busy, 0);
                    done = 1;
                end
            end
        end
        if (!done) chk("frame_timeout", 0, 1);
        chk("pixels_consumed", pix_idx, W*H);
        i_in_valid = 1'b0; i_out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("frame_done_one_cycle", o_frame_done, 0);
    endtask

    initial begin
        rst = 1'b0;
        i_start = 0; i_relu_en = 0; i_wt_we = 0; i_wt_addr = 0; i_wt_data = 0;
        i_in_valid = 0; i_in_data = 0; i_out_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", o_in_ready, 0);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_out_data", o_out_data, 0);
        chk("rst_out_last", o_out_last, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_frame_done", o_frame_done, 0);
        rst = 1'b1;
        @(negedge clk);

        set_identity_frame();
        load_params();
        run_frame(0, 70, -1, 0, 0, 0);

        for (int t = 0; t < KK*KK; t++) wt[1][t] = 16'sh0080;
        bias[1] = 16'sh0100;
        for (int i = 0; i < W*H; i++) pix[i] = 16'sh0200;
        load_params();
        run_frame(0, 100, -1, 0, 0, 1);

        clear_params();
        for (int t = 0; t < KK*KK; t++) wt[0][t] = 16'sh0100;
        load_params();
        for (int i = 0; i < W*H; i++) pix[i] = 16'sh7F00;
        run_frame(0, 80, -1, 0, 0, 0);
        for (int i = 0; i < W*H; i++) pix[i] = shortint'(16'h8100);
        run_frame(0, 80, -1, 0, 0, 0);
        run_frame(1, 80, -1, 0, 0, 0);

        set_identity_frame();
        load_params();
        run_frame(0, 100, 3, 0, 0, 0);
        run_frame(0, 60, -1, 1, 0, 0);
        run_frame(0, 60, -1, 0, 1, 0);
        chk("after_abort_idle", o_busy, 0);
        run_frame(0, 60, -1, 0, 0, 0);

        for (int f = 0; f < 3; f++) begin
            for (int ch = 0; ch < NC; ch++) begin
                bias[ch] = shortint'(int'($urandom_range(0, 2047)) - 1024);
                for (int t = 0; t < KK*KK; t++)
                    wt[ch][t] = shortint'(int'($urandom_range(0, 1023)) - 512);
            end
            for (int i = 0; i < W*H; i++) pix[i] = shortint'(int'($urandom_range(0, 8191)) - 4096);
            load_params();
            run_frame(bit'($urandom_range(0, 1)), 50 + f*20, (f == 1) ? 6 : -1, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_stream_engine.md
Name: conv_stream_engine

Overview:
- Sequential, parametrised convolution layer engine for the LeNet-1 accelerator. Replaces the fully combinational per-feature-map convolution blocks.
- Accepts one image frame as a raster-order pixel stream and buffers K rows on chip.
- For every valid KxK window it computes NUM_CH output feature values in parallel:
  - time-multiplexed MAC, one tap per cycle;
  - per-channel bias;
  - saturation and optional ReLU.
- Results are streamed out through a valid/ready handshake. Serves conv1 (1 input map, 4 channels) and, instantiated per input map, conv2.

Parameters:
- FP_LENGTH, 16, signed fixed-point word width of pixels, weights, biases and outputs.
- FRAC_BITS, 8, fractional bits of the fixed-point format.
- K, 5, kernel edge length (window is KxK).
- IMG_W, 28, input image width in pixels.
- IMG_H, 28, input image height in pixels.
- NUM_CH, 4, number of output channels computed in parallel.
- ACC_W, 2*FP_LENGTH+8, accumulator width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
- relu_en  in  1  ReLU enable, sampled on an accepted start
- wt_we  in  1  parameter write strobe
- wt_addr  in  clog2(NUM_CH*K*K+NUM_CH)  parameter address
- wt_data  in  FP_LENGTH  parameter value
- in_valid  in  1  pixel valid
- in_ready  out  1  engine can accept a pixel
- in_data  in  FP_LENGTH  pixel value
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts the output vector
- out_data  out  NUM_CH*FP_LENGTH  channel c occupies bits [c*FP_LENGTH +: FP_LENGTH]
- out_last  out  1  marks the final output vector of the frame
- busy  out  1  high whenever state is not IDLE
- frame_done  out  1  one-cycle pulse after the final output is accepted

Behaviour:
Reset and clock:
- Reset rst, asynchronous, active-low; clock clk.
- On reset: state=IDLE; in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, frame_done=0; row/col/tap counters=0.
- Weight and bias storage is not cleared by reset.

Parameter writes:
- Address map: 0..NUM_CH*K*K-1 are weights, at address ch*K*K + ky*K + kx. The next NUM_CH addresses are bias[ch].
- Writes are performed only in IDLE. Writes in any other state, or to out-of-range addresses, are ignored.

State machine (IDLE, ACCEPT, MAC, OUT):
- IDLE:
  - busy=0, in_ready=0.
  - start=1: clear row/col, latch relu_en, go to ACCEPT.
- ACCEPT:
  - in_ready=1.
  - On in_valid&in_ready: store the pixel at line buffer [row mod K][col], then advance col (wrapping at IMG_W, incrementing row).
  - If the accepted pixel has row>=K-1 and col>=K-1, go to MAC. Otherwise stay in ACCEPT, taking one pixel per cycle.
- MAC:
  - in_ready=0.
  - Runs exactly K*K cycles, tap t=0..K*K-1, with ky=t/K and kx=t%K.
  - Each cycle, for every channel ch: acc[ch] += pix(r-K+1+ky, c-K+1+kx) * w[ch][t], where (r,c) is the triggering pixel.
  - Products are full 2*FP_LENGTH signed. acc is cleared at MAC entry.
- OUT:
  - out_valid=1 from the cycle after the last MAC cycle. For a triggering pixel accepted in cycle T, out_valid rises in cycle T+K*K+1.
  - Per-channel result: (acc + (bias sign-extended << FRAC_BITS)) >>> FRAC_BITS, arithmetic shift (floor).
  - The result is saturated to [-2^(FP_LENGTH-1), 2^(FP_LENGTH-1)-1]. If relu_en was latched, negative results become 0.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: if the triggering pixel was (IMG_H-1, IMG_W-1), pulse frame_done next cycle and go to IDLE. Otherwise go to ACCEPT.
  - out_last=1 only for that final output.

Throughput and ordering:
- Outputs per frame: (IMG_H-K+1)*(IMG_W-K+1), emitted in raster order.
- Window outputs cost K*K+1 cycles plus any backpressure. Non-window pixels cost 1 cycle each.

Boundary conditions:
- start while busy is ignored.
- in_valid while in_ready=0 is not consumed and the pixel is not lost.
- out_ready held high on entry to OUT gives a one-cycle OUT.
- Accumulator overflow cannot occur for ACC_W >= 2*FP_LENGTH + clog2(K*K) + 1.
- An asynchronous reset at any point, including mid-MAC or mid-OUT, aborts the frame immediately.
- After any reset, a new start must be accepted and produce correct results using the retained weights.

Test Plan:
Bench parameters for all scenarios: K=3, IMG_W=IMG_H=5, NUM_CH=2, FP_LENGTH=16, FRAC_BITS=8.
1. Identity kernel: ch0 centre weight 0x0100, all other weights and biases 0; pixels (r*5+c)<<8 -> 9 outputs. ch0 = 0x0600,0x0700,0x0800,0x0B00,0x0C00,0x0D00,0x1000,0x1100,0x1200; ch1 = 0; out_last only on the 9th; frame_done one cycle after the 9th acceptance.
2. Bias plus multi-channel: ch1 weights all 0x0080, bias[1]=0x0100; all pixels 0x0200 -> ch1 = 0x0A00 on every output. The first out_valid appears exactly 10 cycles after the 13th pixel handshake.
3. Saturation/ReLU: all ch0 weights 0x0100.
   - Pixels 0x7F00 -> 0x7FFF.
   - Pixels 0x8100 with relu_en=0 -> 0x8000.
   - Pixels 0x8100 with relu_en=1 -> 0x0000.
4. Backpressure: hold out_ready=0 for 20 cycles at the 4th output -> out_valid stays 1, out_data/out_last stay stable, in_ready=0. Results equal scenario 1 with no pixel lost or duplicated.
5. Protection: a wt_we to address 4 with 0x7FFF while busy, plus a start pulse mid-frame -> both ignored, and outputs match scenario 1.
6. Reset mid-MAC: assert rst during MAC of the 5th output -> all outputs go 0 asynchronously and busy=0. A new start and the same frame -> scenario 1 results with weights retained.
